// File: rtl/rram_pkg.sv
// Shared types and constants for the RRAM operation sequencer.
package rram_pkg;

  typedef enum logic [1:0] {
    ModeReadCsa = 2'd0,
    ModeReadAdc = 2'd1,
    ModeSet     = 2'd2,
    ModeReset   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPrech,
    StPulse,
    StSense,
    StCapture,
    StDone
  } state_e;

  // Line level codes as {IN1, IN0}
  localparam logic [1:0] LvlV1 = 2'b00;
  localparam logic [1:0] LvlV2 = 2'b01;
  localparam logic [1:0] LvlV3 = 2'b10;
  localparam logic [1:0] LvlV4 = 2'b11;

  // Register select, address bits [4:2]
  localparam logic [2:0] RegCmd     = 3'd0;
  localparam logic [2:0] RegPw      = 3'd1;
  localparam logic [2:0] RegColmask = 3'd2;
  localparam logic [2:0] RegResult  = 3'd3;
  localparam logic [2:0] RegStatus  = 3'd4;

  function automatic logic [1:0] popcount3(input logic a, input logic b, input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/rram_op_sequencer_if.sv
// Register bus between a host and the RRAM operation sequencer.
interface rram_op_sequencer_if;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wishbone_address_bus;
  logic [31:0] wishbone_data_in;
  logic [31:0] wishbone_data_out;
  logic        wbs_ack_o;

  modport master (
    output wbs_stb_i, wbs_we_i, wishbone_address_bus, wishbone_data_in,
    input  wishbone_data_out, wbs_ack_o
  );

  modport slave (
    input  wbs_stb_i, wbs_we_i, wishbone_address_bus, wishbone_data_in,
    output wishbone_data_out, wbs_ack_o
  );
endinterface

// File: rtl/rram_sync_fifo.sv
// Single-clock result FIFO; DEPTH must be a power of two so pointers wrap naturally.
module rram_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rram_op_sequencer.sv
// Sequences RRAM crossbar READ_CSA/READ_ADC/SET/RESET operations behind a register bus.
// Define RRAM_VERIFY_EN to add a CSA read-back verify after each SET/RESET pulse.
module rram_op_sequencer
  import rram_pkg::*;
#(
  parameter int unsigned ROWS       = 16,
  parameter int unsigned COLS       = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PW_BITS    = 8
) (
  input  logic               clk,
  input  logic               rst,
  rram_op_sequencer_if.slave bus,
  input  logic               start_operation,
  output logic               busy,
  output logic               ENABLE_WL,
  output logic               ENABLE_BL,
  output logic               ENABLE_SL,
  output logic               PRE,
  output logic               SAEN_CSA,
  output logic [1:0]         CLK_EN_ADC,
  output logic [ROWS-1:0]    IN1_WL,
  output logic [ROWS-1:0]    IN0_WL,
  output logic [COLS-1:0]    IN1_BL,
  output logic [COLS-1:0]    IN0_BL,
  output logic [COLS-1:0]    IN1_SL,
  output logic [COLS-1:0]    IN0_SL,
  input  logic [COLS-1:0]    CSA,
  input  logic [COLS-1:0]    ADC_OUT0,
  input  logic [COLS-1:0]    ADC_OUT1,
  input  logic [COLS-1:0]    ADC_OUT2
);
  state_e             state_q, state_d;
  mode_e              mode_q, eff_mode;
  logic [7:0]         row_q;
  logic [PW_BITS-1:0] pw_q, pw_eff, cnt_q, cnt_d;
  logic [COLS-1:0]    mask_q;
  logic               verify_q, verify_d;
  logic               error_q, vfail_q, err_set, vfail_set;
  logic               ack_q;
  logic [31:0]        rdata_q, rdata_d, capture_data;
  logic               push, fifo_full, fifo_empty;
  logic [31:0]        fifo_rdata;
  logic [2:0]         reg_sel;
  logic               wr, rd, rd_result, rd_status, is_read, row_ok, mismatch;
  logic [1:0]         wl_code, bl_code, sl_code;
  logic               unused_bus;

  assign reg_sel   = bus.wishbone_address_bus[4:2];
  assign wr        = bus.wbs_stb_i & bus.wbs_we_i;
  assign rd        = bus.wbs_stb_i & ~bus.wbs_we_i;
  assign rd_result = rd & (reg_sel == RegResult);
  assign rd_status = rd & (reg_sel == RegStatus);
  assign unused_bus = ^{bus.wishbone_address_bus[31:5], bus.wishbone_address_bus[1:0],
                        bus.wishbone_data_in};

  assign bus.wbs_ack_o         = ack_q;
  assign bus.wishbone_data_out = rdata_q;

  assign busy     = (state_q != StIdle);
  assign pw_eff   = (pw_q == '0) ? PW_BITS'(1) : pw_q;
  assign is_read  = (mode_q == ModeReadCsa) || (mode_q == ModeReadAdc);
  assign row_ok   = (32'(row_q) < ROWS);
  // The verify phase after a write senses like a plain CSA read
  assign eff_mode = verify_q ? ModeReadCsa : mode_q;
  assign mismatch = (CSA & mask_q) != ((mode_q == ModeSet) ? mask_q : '0);

  always_comb begin
    rdata_d = '0;
    case (reg_sel)
      RegCmd:     rdata_d = {22'b0, mode_q, row_q};
      RegPw:      rdata_d = 32'(pw_q);
      RegColmask: rdata_d = 32'(mask_q);
      RegResult:  rdata_d = fifo_empty ? '0 : fifo_rdata;
      RegStatus:  rdata_d = {28'b0, vfail_q, error_q, fifo_full, fifo_empty};
      default:    rdata_d = '0;
    endcase
  end

  always_comb begin
    capture_data = '0;
    if (mode_q == ModeReadAdc) begin
      for (int c = 0; c < COLS; c++) begin
        capture_data[2*c +: 2] = popcount3(ADC_OUT0[c], ADC_OUT1[c], ADC_OUT2[c]);
      end
    end else begin
      capture_data[COLS-1:0] = CSA;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    verify_d  = verify_q;
    push      = 1'b0;
    err_set   = 1'b0;
    vfail_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_operation) begin
          if (!row_ok || (is_read && fifo_full)) err_set = 1'b1;
          else                                   state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = pw_eff - PW_BITS'(1);
        state_d = is_read ? StPrech : StPulse;
      end
      StPrech: begin
        if (cnt_q == '0) state_d = StSense;
        else             cnt_d   = cnt_q - PW_BITS'(1);
      end
      StPulse: begin
        if (cnt_q == '0) begin
`ifdef RRAM_VERIFY_EN
          state_d  = StPrech;
          cnt_d    = pw_eff - PW_BITS'(1);
          verify_d = 1'b1;
`else
          state_d  = StDone;
`endif
        end else begin
          cnt_d = cnt_q - PW_BITS'(1);
        end
      end
      StSense:   state_d = StCapture;
      StCapture: begin
        if (verify_q) vfail_set = mismatch;
        else          push      = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        verify_d = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wl_code = LvlV1;
    bl_code = LvlV1;
    sl_code = LvlV1;
    unique case (eff_mode)
      ModeReadCsa, ModeReadAdc: begin wl_code = LvlV2; bl_code = LvlV2; end
      ModeSet:                  begin wl_code = LvlV3; bl_code = LvlV4; end
      ModeReset:                begin wl_code = LvlV3; sl_code = LvlV4; end
      default: ;
    endcase
    for (int r = 0; r < ROWS; r++) begin
      {IN1_WL[r], IN0_WL[r]} = (busy && row_q == 8'(r)) ? wl_code : LvlV1;
    end
    for (int c = 0; c < COLS; c++) begin
      {IN1_BL[c], IN0_BL[c]} = (busy && mask_q[c]) ? bl_code : LvlV1;
      {IN1_SL[c], IN0_SL[c]} = (busy && mask_q[c]) ? sl_code : LvlV1;
    end
    PRE        = (state_q == StPrech);
    ENABLE_WL  = (state_q == StPulse) || (state_q == StSense);
    ENABLE_BL  = ENABLE_WL;
    ENABLE_SL  = ENABLE_WL;
    SAEN_CSA   = (state_q == StSense) && (eff_mode == ModeReadCsa);
    CLK_EN_ADC = ((state_q == StSense) && (eff_mode == ModeReadAdc)) ? 2'b11 : 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      verify_q <= 1'b0;
      mode_q   <= ModeReadCsa;
      row_q    <= '0;
      pw_q     <= '0;
      mask_q   <= '0;
      error_q  <= 1'b0;
      vfail_q  <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      verify_q <= verify_d;
      ack_q    <= bus.wbs_stb_i;
      rdata_q  <= rd ? rdata_d : '0;
      if (wr && !busy) begin
        case (reg_sel)
          RegCmd: begin
            mode_q <= mode_e'(bus.wishbone_data_in[9:8]);
            row_q  <= bus.wishbone_data_in[7:0];
          end
          RegPw:      pw_q   <= bus.wishbone_data_in[PW_BITS-1:0];
          RegColmask: mask_q <= bus.wishbone_data_in[COLS-1:0];
          default: ;
        endcase
      end
      if (rd_status) begin
        error_q <= 1'b0;
        vfail_q <= 1'b0;
      end
      // A new event in the same cycle as a STATUS read stays visible
      if (err_set)   error_q <= 1'b1;
      if (vfail_set) vfail_q <= 1'b1;
    end
  end

  rram_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (rd_result),
    .wdata (capture_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: doc/rram_op_sequencer.md
RRAM_OP_SEQUENCER -- requirements
Module: rram_op_sequencer

Interface
REQ-001 Parameters SHALL be: ROWS (16, word lines); COLS (16, bit/source lines, 1..16); FIFO_DEPTH (8, result entries, power of 2); PW_BITS (8, pulse-width counter width).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- wbs_stb_i  in  1  bus strobe, one access per strobe
- wbs_we_i  in  1  bus write enable
- wishbone_address_bus  in  32  register select, bits [4:2]
- wishbone_data_in  in  32  write data
- wishbone_data_out  out  32  read data
- wbs_ack_o  out  1  single-cycle ack
- start_operation  in  1  launch the programmed command
- busy  out  1  sequence in progress
- ENABLE_WL / ENABLE_BL / ENABLE_SL  out  1 each  line driver enables
- PRE  out  1  bit-line precharge
- SAEN_CSA  out  1  current sense amplifier enable
- CLK_EN_ADC  out  2  ADC strobe
- IN1_WL, IN0_WL  out  ROWS each  per-row level code
- IN1_BL, IN0_BL, IN1_SL, IN0_SL  out  COLS each  per-column level code
- CSA  in  COLS  sense amplifier result
- ADC_OUT0..ADC_OUT2  in  COLS each  thermometer ADC result

Function
REQ-003 Registers SHALL be: 0 CMD {mode[1:0] at [9:8], row[7:0]}; 1 PW pulse width; 2 COLMASK[COLS-1:0]; 3 RESULT (read pops the FIFO); 4 STATUS {verify_fail[3], error[2], fifo_full[1], fifo_empty[0]}.
REQ-004 wbs_ack_o SHALL assert exactly one cycle after each wbs_stb_i cycle; read data SHALL be valid in the ack cycle.
REQ-005 Writes to CMD/PW/COLMASK while busy=1 SHALL be acked and discarded.
REQ-006 Modes SHALL be: 0 READ_CSA, 1 READ_ADC, 2 SET, 3 RESET.
REQ-007 Level codes {IN1,IN0} SHALL be: 00=V1, 01=V2, 10=V3, 11=V4; unselected lines and idle lines SHALL be 00.
REQ-008 Selected-line codes SHALL be:
- read: WL(row)=01, BL(mask)=01, SL=00
- SET: WL(row)=10, BL(mask)=11, SL=00
- RESET: WL(row)=10, SL(mask)=11, BL=00
REQ-009 FSM states SHALL be IDLE, SETUP, PRECH, PULSE, SENSE, CAPTURE, DONE.
REQ-010 Transitions SHALL be:
- IDLE→SETUP on start_operation.
- SETUP (1 cycle, codes driven) → PRECH for reads, or → PULSE for writes.
- PRECH: PRE=1 for PW cycles, then → SENSE.
- SENSE (1 cycle): ENABLE_*=1; plus SAEN_CSA=1 (READ_CSA) or CLK_EN_ADC=2'b11 (READ_ADC); then → CAPTURE.
- PULSE: ENABLE_*=1 for PW cycles, then → DONE.
- CAPTURE (1 cycle): push the result, then → DONE.
- DONE (1 cycle) → IDLE.
REQ-011 PW=0 SHALL behave as PW=1; the pulse count SHALL be exact: PULSE lasts PW cycles.
REQ-012 busy SHALL be 1 in every state except IDLE.
REQ-013 FIFO entry width SHALL be 32:
- READ_CSA: {zero, CSA}.
- READ_ADC: for each column c, bits [2c+1:2c] SHALL be the popcount of ADC_OUT0..2[c] (0..3).
REQ-014 start_operation while busy SHALL be ignored.
REQ-015 A read start while the FIFO is full SHALL not launch and SHALL set sticky error; a STATUS read SHALL clear error.
REQ-016 RESULT read when empty SHALL return 0 and SHALL not change the FIFO.
REQ-017 A same-cycle CAPTURE push and bus pop SHALL both take effect; the count SHALL be unchanged.
REQ-018 Row ≥ ROWS SHALL set error and SHALL not launch.
REQ-019 Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-020 rst SHALL asynchronously return the FSM to IDLE, empty the FIFO, zero all registers and flags, and drive every output to 0 (fifo_empty=1), including mid-pulse.

Configuration
REQ-021 With RRAM_VERIFY_EN defined:
- After SET/RESET PULSE, the FSM SHALL perform PRECH→SENSE as READ_CSA.
- It SHALL compare CSA&COLMASK against the expected value (COLMASK for SET, 0 for RESET).
- On mismatch it SHALL set sticky verify_fail (cleared by a STATUS read), with no FIFO push.
REQ-022 Without RRAM_VERIFY_EN, writes SHALL go PULSE→DONE and verify_fail SHALL read 0.

Structure
REQ-023 Package rram_pkg SHALL hold the mode enum, FSM state enum, level-code constants and register offsets.
REQ-024 The FIFO SHALL be sub-module rram_sync_fifo (parametrised width/depth, with full/empty flags).

Verification
REQ-025 The bench SHALL cover these scenarios:
- CMD={SET,row 3}, PW=5, COLMASK=0x00F0, start → IN1:IN0_WL[3]=10, BL[7:4]=11, ENABLE_* high exactly 5 cycles, busy drops after DONE.
- READ_CSA row 0, PW=2, CSA=0xA5A5 → PRE 2 cycles, SAEN_CSA 1 cycle, RESULT read returns 0x0000A5A5, fifo_empty=1 after.
- READ_ADC with column-0 thermometer 011 and others 111 → RESULT=0xFFFFFFFE.
- Nine READ_CSA starts with DEPTH=8, no pops → ninth start rejected, error=1, STATUS read clears it.
- rst asserted mid-PULSE → all outputs 0 immediately, busy=0, FIFO empty.
- RRAM_VERIFY_EN, SET COLMASK=0x3 with CSA=0x1 → verify_fail=1, FIFO unchanged.
